// File: rtl/ring_monitor_pkg.sv
// Shared definitions for the ring monitor: FSM encoding, ring geometry and
// the phase-successor helper used by both the monitor and anyone modelling it.
package ring_monitor_pkg;

  localparam int RING_LEN = 5;
  localparam int PHASE_W  = 3;

  // Encoding 2'b11 is never entered; the monitor treats it like FAULT.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } state_e;

  // Expected next stage of the ring, wrapping from the last stage to stage 0.
  function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] p);
    return (p == PHASE_W'(RING_LEN - 1)) ? '0 : p + PHASE_W'(1);
  endfunction

endpackage : ring_monitor_pkg

// File: rtl/ring_monitor_if.sv
// Sample/status bundle between the ring counter side (master) and the
// monitor (slave). Clock and clear stay as plain ports on the monitor.
interface ring_monitor_if
  import ring_monitor_pkg::*;
#(
  parameter int REV_W = 8
) ();

  logic [RING_LEN-1:0] ring;      // bit4 = stage a .. bit0 = stage e
  logic                en;        // sample strobe
  logic                ack_err;   // fault acknowledge / re-arm
  logic [PHASE_W-1:0]  phase;     // stage index of last legal sample
  logic                valid;     // last sample was one-hot
  logic                seq_err;   // one-cycle out-of-order pulse
  logic                err;       // sticky fault
  logic [REV_W-1:0]    rev_count; // completed revolutions, wraps silently
  state_e              state;     // current FSM state

  modport master (
    output ring, en, ack_err,
    input  phase, valid, seq_err, err, rev_count, state
  );

  modport slave (
    input  ring, en, ack_err,
    output phase, valid, seq_err, err, rev_count, state
  );

endinterface : ring_monitor_if

// File: rtl/ring_monitor_decode.sv
// Combinational one-hot decoder for the five-stage ring: reports whether the
// sample is legal (exactly one bit set) and which stage is set.
module ring_decode
  import ring_monitor_pkg::*;
(
  input  logic [RING_LEN-1:0] ring,
  output logic                legal,
  output logic [PHASE_W-1:0]  phase
);

  // Map each one-hot pattern to its stage index; everything else is illegal.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    legal = 1'b0;
    phase = '0;
    case (ring)
      5'b10000: begin legal = 1'b1; phase = 3'd0; end
      5'b01000: begin legal = 1'b1; phase = 3'd1; end
      5'b00100: begin legal = 1'b1; phase = 3'd2; end
      5'b00010: begin legal = 1'b1; phase = 3'd3; end
      5'b00001: begin legal = 1'b1; phase = 3'd4; end
      default:  begin legal = 1'b0; phase = '0;   end
    endcase
  end

endmodule : ring_decode

// File: rtl/ring_monitor.sv
// Ring monitor: watches the outputs of a five-stage one-hot ring counter,
// locks onto the first legal sample, checks that every following sample is
// the correct successor, counts completed revolutions and latches a sticky
// fault on any illegal or out-of-order sample until it is acknowledged.
// All outputs are registered, so the response appears one edge after the
// sampling edge.
module ring_monitor
  import ring_monitor_pkg::*;
#(
  parameter int REV_W = 8
) (
  input  logic           clk,
  input  logic           clear,   // asynchronous, active-low
  ring_monitor_if.slave  bus
);

  state_e             state_q, state_n;
  logic [PHASE_W-1:0] phase_q, phase_n;
  logic               valid_q, valid_n;
  logic               seq_err_q, seq_err_n;
  logic               err_q, err_n;
  logic [REV_W-1:0]   rev_q, rev_n;

  logic               legal;
  logic [PHASE_W-1:0] dec_phase;

  ring_decode u_decode (
    .ring  (bus.ring),
    .legal (legal),
    .phase (dec_phase)
  );

  // State and output registers; clear takes effect immediately, without clk.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      valid_q   <= 1'b0;
      seq_err_q <= 1'b0;
      err_q     <= 1'b0;
      rev_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the same pre-edge state.
      state_q   <= state_n;
      phase_q   <= phase_n;
      valid_q   <= valid_n;
      seq_err_q <= seq_err_n;
      err_q     <= err_n;
      rev_q     <= rev_n;
    end
  end

  // Next-state and next-output logic: hold by default, seq_err is a pulse.
  always_comb begin
    state_n   = state_q;
    phase_n   = phase_q;
    valid_n   = valid_q;
    seq_err_n = 1'b0;
    err_n     = err_q;
    rev_n     = rev_q;

    if (bus.ack_err) begin
      // Acknowledge wins over a simultaneous sample; the revolution count
      // survives so long-term statistics are not lost on a fault.
      state_n = IDLE;
      valid_n = 1'b0;
      err_n   = 1'b0;
    end else if (bus.en) begin
      case (state_q)
        IDLE: begin
          // Start-up tolerance: illegal samples before lock are not faults.
          if (legal) begin
            phase_n = dec_phase;
            valid_n = 1'b1;
            state_n = TRACK;
          end else begin
            valid_n = 1'b0;
          end
        end

        TRACK: begin
          if (legal && (dec_phase == next_phase(phase_q))) begin
            phase_n = dec_phase;
            valid_n = 1'b1;
            if (dec_phase == '0) begin
              rev_n = rev_q + REV_W'(1);
            end
          end else if (legal) begin
            // Legal but wrong successor, including a repeated stage.
            phase_n   = dec_phase;
            valid_n   = 1'b1;
            seq_err_n = 1'b1;
            err_n     = 1'b1;
            state_n   = FAULT;
          end else begin
            valid_n = 1'b0;
            err_n   = 1'b1;
            state_n = FAULT;
          end
        end

        default: begin
          // FAULT (and the unused encoding): ignore samples until acknowledged.
          state_n = FAULT;
          err_n   = 1'b1;
        end
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.phase     = phase_q;
  assign bus.valid     = valid_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.err       = err_q;
  assign bus.rev_count = rev_q;

endmodule : ring_monitor
